sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Event-driven square-wave sound generator for the dino game. It consumes the one-cycle `jump_pulse` and `game_over_pulse` strobes from the player controller and the 60 Hz frame tick from the graphics timing. It drives the single-bit speaker output on `uio_out[7]`. A small state machine sequences a short jump chirp and a two-note descending game-over jingle. Note lengths are counted in frames and pitch is set by clock-cycle half-period counters.

## Interface
- `TONE_W`, 16: width of half-period counter and tone parameters.
- `JUMP_HALF`, 12587: jump tone half-period in clk cycles (about 1 kHz at 25.175 MHz).
- `OVER_HALF_0`, 25175: first game-over note half-period (about 500 Hz).
- `OVER_HALF_1`, 37762: second game-over note half-period (about 333 Hz).
- `JUMP_FRAMES`, 6: jump tone length in frame ticks, range 1..31.
- `OVER_FRAMES`, 15: length of each game-over note in frame ticks, range 1..31.
- `GAP_FRAMES`, 4: silent gap between game-over notes, range 1..31. Used only with the macro.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_frame_tick`  in  1  one-cycle 60 Hz strobe.
- `i_jump_pulse`  in  1  one-cycle jump strobe.
- `i_game_over_pulse`  in  1  one-cycle game-over strobe.
- `i_mute`  in  1  level; forces silence without stopping the sequencer.
- `o_sound`  out  1  registered square wave.
- `o_busy`  out  1  registered; high whenever state ≠ IDLE.

## Operation
- States: IDLE, JUMP, OVER1, (GAP), OVER2.
- IDLE: `o_sound`=0. On `i_jump_pulse` go to JUMP.
- JUMP: tone `JUMP_HALF`. After `JUMP_FRAMES` frame ticks go to IDLE. A new `i_jump_pulse` restarts JUMP: frame count, tone counter and `o_sound` are cleared.
- OVER1: tone `OVER_HALF_0`. After `OVER_FRAMES` ticks go to OVER2, or to GAP when the macro is enabled.
- GAP: silent. After `GAP_FRAMES` ticks go to OVER2.
- OVER2: tone `OVER_HALF_1`. After `OVER_FRAMES` ticks go to IDLE.
- `i_game_over_pulse` in any state, including OVER1/GAP/OVER2, enters or restarts OVER1.
- `i_jump_pulse` is ignored in OVER1, GAP and OVER2.
- Both pulses in the same cycle: game over wins and the state goes to OVER1.
- Every state entry, including a restart into the same state, clears:
  - the 5-bit frame counter,
  - the TONE_W-bit half-period counter,
  - the internal tone flop.
- Tone generation:
  - The half-period counter increments every clk.
  - At `HALF-1` it wraps to 0 and toggles the tone flop.
  - In IDLE and GAP the counter is held at 0 and the flop at 0.
- Frame counting: the frame counter increments on `i_frame_tick`. A tick that arrives while the count is `N-1` causes the state transition on that edge.
- `o_sound` = tone flop AND NOT `i_mute`. This gate is registered, so mute takes effect with 1 cycle of latency.
- All `*_HALF` parameters must be ≥2. `*_FRAMES` values are 5-bit unsigned. Widths outside these ranges are unsupported.

## Timing
- Reset (asynchronous, `rst_n` low): state=IDLE, all counters 0, `o_sound`=0, `o_busy`=0. This takes effect immediately, including mid-note.
- Pulse sampled at edge E: the state and `o_busy` update at E.
- First rising edge of the tone flop: E+HALF.
- `o_sound` follows the tone flop one cycle later, so it first rises at E+HALF+1.
- Tone period is 2×HALF clk cycles, with a 50% duty cycle.
- State-exit transitions occur on the edge that samples the terminating frame tick. The tone flop clears on that same edge.
- Game-over sequence length is `2×OVER_FRAMES` frame ticks, or `2×OVER_FRAMES+GAP_FRAMES` with the gap compiled in.

## Configuration
- `SOUND_SEQ_GAP_EN`:
  - Defined: the GAP state exists. OVER1 goes to GAP, and GAP goes to OVER2 after `GAP_FRAMES` ticks with `o_sound`=0 and `o_busy`=1.
  - Undefined: GAP is not synthesized, `GAP_FRAMES` is unused, and OVER1 goes directly to OVER2.

## Test plan
- Reset mid-note: JUMP active with `o_sound`=1, drive `rst_n`=0 → `o_sound`=0 and `o_busy`=0 within the same cycle. After release, the block stays in IDLE with no toggling.
- Jump chirp (`JUMP_HALF`=4, `JUMP_FRAMES`=3): pulse at edge E → `o_busy`=1 at E. `o_sound` rises at E+5 and toggles every 4 clk. After the 3rd frame tick → IDLE, `o_sound`=0.
- Jump retrigger: second `i_jump_pulse` after 2 frame ticks → the counters clear. The block stays busy for 3 more ticks after the retrigger.
- Game over during jump, and simultaneous pulses (`OVER_HALF_0`=6, `OVER_HALF_1`=9, `OVER_FRAMES`=2): the block enters OVER1 with a 12-cycle period. After 2 ticks it moves to OVER2 with an 18-cycle period, and after 2 more ticks to IDLE. Repeating the run with both pulses in the same cycle gives the same trace.
- Jump ignored in OVER2: pulse `i_jump_pulse` during OVER2 → no restart and the tone is unchanged. Pulse `i_game_over_pulse` during OVER2 → the block restarts in OVER1.
- Mute and gap: `i_mute`=1 during OVER1 → `o_sound`=0 from the next cycle while `o_busy` stays 1 and the sequence timing is unchanged. With `SOUND_SEQ_GAP_EN` and `GAP_FRAMES`=2: between the notes there are 2 silent frame ticks with `o_busy`=1.

Source files
------------

// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: strobes, mute level and speaker/busy outputs of the
// dino-game sound sequencer. The master side drives the pulses, the slave
// side is the sequencer itself.
interface sound_sequencer_if;
    logic i_frame_tick;
    logic i_jump_pulse;
    logic i_game_over_pulse;
    logic i_mute;
    logic o_sound;
    logic o_busy;

    modport master (
        output i_frame_tick,
        output i_jump_pulse,
        output i_game_over_pulse,
        output i_mute,
        input  o_sound,
        input  o_busy
    );

    modport slave (
        input  i_frame_tick,
        input  i_jump_pulse,
        input  i_game_over_pulse,
        input  i_mute,
        output o_sound,
        output o_busy
    );
endinterface

// File: rtl/sound_sequencer.sv
// sound_sequencer: event-driven square-wave generator for the dino game.
// A jump strobe plays a short chirp, a game-over strobe plays a two-note
// descending jingle. Note lengths are counted in 60 Hz frame ticks, pitch is
// set by a clk-cycle half-period counter.
// Optional feature macro: SOUND_SEQ_GAP_EN inserts a silent GAP state of
// GAP_FRAMES ticks between the two game-over notes.
module sound_sequencer #(
    parameter int TONE_W      = 16,
    parameter int JUMP_HALF   = 12587,
    parameter int OVER_HALF_0 = 25175,
    parameter int OVER_HALF_1 = 37762,
    parameter int JUMP_FRAMES = 6,
    parameter int OVER_FRAMES = 15,
    parameter int GAP_FRAMES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sound_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        JUMP  = 3'd1,
        OVER1 = 3'd2,
        GAP   = 3'd3,
        OVER2 = 3'd4
    } state_t;

    state_t            state;
    logic [4:0]        frame_cnt;
    logic [TONE_W-1:0] half_cnt;
    logic              tone;
    logic              sound_out;
    logic              busy_out;

    // Per-state decode: tone wrap point, last frame count, exit target.
    logic [TONE_W-1:0] half_last;
    logic [4:0]        frame_last;
    logic              silent;
    state_t            exit_state;

    // Decode the current state's note parameters
    always_comb begin
        half_last  = '0;
        frame_last = '0;
        silent     = 1'b1;
        exit_state = IDLE;
        case (state)
            JUMP: begin
                half_last  = TONE_W'(JUMP_HALF - 1);
                frame_last = 5'(JUMP_FRAMES - 1);
                silent     = 1'b0;
                exit_state = IDLE;
            end
            OVER1: begin
                half_last  = TONE_W'(OVER_HALF_0 - 1);
                frame_last = 5'(OVER_FRAMES - 1);
                silent     = 1'b0;
`ifdef SOUND_SEQ_GAP_EN
                exit_state = GAP;
`else
                exit_state = OVER2;
`endif
            end
            // Only reachable when OVER1 exits into it; otherwise optimised away.
            GAP: begin
                frame_last = 5'(GAP_FRAMES - 1);
                exit_state = OVER2;
            end
            OVER2: begin
                half_last  = TONE_W'(OVER_HALF_1 - 1);
                frame_last = 5'(OVER_FRAMES - 1);
                silent     = 1'b0;
                exit_state = IDLE;
            end
            default: begin
                silent = 1'b1;
            end
        endcase
    end

    // Entry events: game over beats jump, jump only accepted in IDLE/JUMP.
    logic   jump_start;
    logic   frame_done;
    logic   enter;
    state_t enter_state;

    // Select which state (if any) is entered on this edge
    always_comb begin
        jump_start  = bus.i_jump_pulse && (state == IDLE || state == JUMP);
        frame_done  = bus.i_frame_tick && (state != IDLE) && (frame_cnt == frame_last);
        enter       = bus.i_game_over_pulse || jump_start || frame_done;
        enter_state = exit_state;
        if (bus.i_game_over_pulse) begin
            enter_state = OVER1;
        end else if (jump_start) begin
            enter_state = JUMP;
        end
    end

    // Sequencer FSM with frame/half-period counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            half_cnt  <= '0;
            tone      <= 1'b0;
            sound_out <= 1'b0;
            busy_out  <= 1'b0;
        end else if (enter) begin
            // Every entry, including a restart, starts the note from scratch.
            state     <= enter_state;
            busy_out  <= (enter_state != IDLE);
            frame_cnt <= '0;
            half_cnt  <= '0;
            tone      <= 1'b0;
            sound_out <= 1'b0;
        end else begin
            if (bus.i_frame_tick && state != IDLE) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
            if (silent) begin
                half_cnt <= '0;
                tone     <= 1'b0;
            end else if (half_cnt == half_last) begin
                half_cnt <= '0;
                tone     <= ~tone;
            end else begin
                half_cnt <= half_cnt + TONE_W'(1);
            end
            // Mute gate is registered, so it lags the mute level by one clk.
            sound_out <= tone & ~bus.i_mute;
        end
    end

    assign bus.o_sound = sound_out;
    assign bus.o_busy  = busy_out;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: table-driven cycle traces for the sound sequencer,
// plus hand-written sequences for reset mid-note and game-over restart.
// Builds with or without SOUND_SEQ_GAP_EN.
module tb_sound_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sound_sequencer_if bus ();

    sound_sequencer #(
        .TONE_W      (16),
        .JUMP_HALF   (4),
        .OVER_HALF_0 (6),
        .OVER_HALF_1 (9),
        .JUMP_FRAMES (3),
        .OVER_FRAMES (2),
        .GAP_FRAMES  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One row = inputs applied at an edge and outputs expected after it.
    typedef struct {
        bit j;
        bit g;
        bit t;
        bit m;
        bit cs;   // compare o_sound on this row
        bit s;
        bit b;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

`ifdef SOUND_SEQ_GAP_EN
    localparam int O2 = 20;   // relative edge where OVER2 is entered
`else
    localparam int O2 = 14;
`endif

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input bit j, input bit g, input bit t, input bit m);
        bus.i_jump_pulse      = j;
        bus.i_game_over_pulse = g;
        bus.i_frame_tick      = t;
        bus.i_mute            = m;
        @(posedge clk);
        #1;
        bus.i_jump_pulse      = 1'b0;
        bus.i_game_over_pulse = 1'b0;
        bus.i_frame_tick      = 1'b0;
    endtask

    task automatic push(input bit j, input bit g, input bit t, input bit m,
                        input bit cs, input bit s, input bit b);
        vec_t v;
        v.j = j; v.g = g; v.t = t; v.m = m; v.cs = cs; v.s = s; v.b = b;
        vecs.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].j, vecs[i].g, vecs[i].t, vecs[i].m);
            check($sformatf("%s[%0d].busy", tag, i), bus.o_busy, vecs[i].b);
            if (vecs[i].cs) begin
                check($sformatf("%s[%0d].sound", tag, i), bus.o_sound, vecs[i].s);
            end
        end
        $display("run %s: %0d rows applied", tag, vecs.size());
        vecs.delete();
        bus.i_mute = 1'b0;
    endtask

    function automatic bit over_tick(input int k);
        bit t;
        t = (k == 4) || (k == 14) || (k == O2 + 6) || (k == O2 + 16);
`ifdef SOUND_SEQ_GAP_EN
        t = t || (k == 17) || (k == 20);
`endif
        return t;
    endfunction

    // Game-over trace from the pulse edge k=0: OVER1 (half 6) sounds at 7..12,
    // OVER2 (half 9) sounds at O2+10..O2+15, exit to IDLE at O2+16.
    task automatic over_trace(input bit jump_same, input int jump_at,
                              input int mlo, input int mhi);
        for (int k = 0; k < O2 + 21; k++) begin
            bit j, m, base;
            j    = (jump_same && k == 0) || (k == jump_at);
            m    = (k >= mlo) && (k <= mhi);
            base = (k >= 7 && k <= 12) || (k >= O2 + 10 && k <= O2 + 15);
            push(j, (k == 0), over_tick(k), m, (k != O2 + 16), base && !m, (k < O2 + 16));
        end
    endtask

    initial begin
        bus.i_jump_pulse      = 1'b0;
        bus.i_game_over_pulse = 1'b0;
        bus.i_frame_tick      = 1'b0;
        bus.i_mute            = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", bus.o_busy, 1'b0);
        check("reset.sound", bus.o_sound, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) push(0, 0, (k == 1), 0, 1, 0, 0);
        run_table("idle");

        // Jump chirp: half 4, 3 frames, sound 1 at E+5..E+8
        for (int k = 0; k < 14; k++) begin
            push((k == 0), 0, (k == 3 || k == 7 || k == 11), 0, 1,
                 (k >= 5 && k <= 8), (k < 11));
        end
        run_table("chirp");

        // Jump retrigger after 2 ticks, while sound is high
        for (int k = 0; k < 18; k++) begin
            bit s;
            s = (k >= 5 && k <= 7) || (k == 13);
            push((k == 0 || k == 8), 0,
                 (k == 3 || k == 7 || k == 10 || k == 12 || k == 14), 0,
                 (k != 14), s, (k < 14));
        end
        run_table("retrig");

        // Game over during a jump
        push(1, 0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 0, 1, 0, 1);
        over_trace(1'b0, -1, -1, -2);
        run_table("over_after_jump");

        // Both pulses on the same edge: game over wins
        over_trace(1'b1, -1, -1, -2);
        run_table("over_both");

        // Mute during OVER1: silent on those rows, timing unchanged
        over_trace(1'b0, -1, 8, 10);
        run_table("over_mute");

        // Jump pulse during OVER2 is ignored
        over_trace(1'b0, O2 + 8, -1, -2);
        run_table("over_jump_ignored");

        // Game-over pulse during OVER2 restarts OVER1
        step(0, 1, 0, 0);
        for (int k = 1; k < O2 + 4; k++) step(0, 0, over_tick(k), 0);
        check("restart.pre_busy", bus.o_busy, 1'b1);
        step(0, 1, 0, 0);
        check("restart.busy", bus.o_busy, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 0);
            check($sformatf("restart.quiet%0d", k), bus.o_sound, 1'b0);
        end
        step(0, 0, 0, 0);
        check("restart.rise", bus.o_sound, 1'b1);
        begin
            int n;
            n = 0;
            while (bus.o_busy && n < 400) begin
                step(0, 0, (n % 5 == 0), 0);
                n++;
            end
            check("restart.drain_idle", bus.o_busy, 1'b0);
        end
        $display("run restart: done");

        // Reset mid-note
        step(1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, 0, 0, 0);
        check("rst_mid.pre_sound", bus.o_sound, 1'b1);
        check("rst_mid.pre_busy", bus.o_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.sound", bus.o_sound, 1'b0);
        check("rst_mid.busy", bus.o_busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) push(0, 0, (k % 3 == 0), 0, 1, 0, 0);
        run_table("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
